// File: rtl/fifo_stream_out_if.sv
// Handshake bundle between fifo_mono's read port, the drain stage and the
// downstream stream consumer.
interface fifo_stream_out_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_read;
  logic [WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_read, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_read, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Drains fifo_mono into a valid/ready stream: a 2-entry skid buffer absorbs the
// fifo's 1-cycle read latency so full-rate streaming has no bubbles.
module fifo_stream_out #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_stream_out_if.master s
);
  localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0][WIDTH-1:0] buf_q;
  logic [1:0]            cnt_q;
  logic                  head_q;
  logic                  tail_q;
  logic                  inflight_q;
  logic [BW-1:0]         beat_q;
  logic                  pop;
  logic [1:0]            occ_nxt;

  assign pop = s.m_valid & s.m_ready;

  // Words owned once this edge completes: buffered plus the one arriving,
  // minus the one leaving. pop implies cnt_q>=1, so no underflow.
  assign occ_nxt = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  // Reads stop as soon as both slots are spoken for, which is what makes a
  // write into a full buffer impossible.
  assign s.fifo_read = rst & ~s.fifo_empty & (occ_nxt < 2'd2);

  assign s.m_valid = (cnt_q != 2'd0);
  assign s.m_data  = s.m_valid ? buf_q[head_q] : '0;
  assign s.m_last  = s.m_valid & (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q      <= '0;
      cnt_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= s.fifo_read;
      cnt_q      <= occ_nxt;
      if (inflight_q) begin
        buf_q[tail_q] <= s.fifo_dout;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: two instances (BURST_LEN 4 and 3) fed from one
// behavioural fifo_mono model, checked against a word/beat-count reference.
module tb_fifo_stream_out;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  // Shared fifo contents; each instance has its own read pointer. base marks
  // the first word written after the latest reset (older words are flushed).
  logic [W-1:0] mem [0:2047];
  int wr = 0;
  int rd4 = 0, base4 = 0, arr4 = 0, n4 = 0;
  int rd3 = 0, base3 = 0, arr3 = 0, n3 = 0;

  fifo_stream_out_if #(.WIDTH(W)) i4 ();
  fifo_stream_out_if #(.WIDTH(W)) i3 ();

  fifo_stream_out #(.WIDTH(W), .BURST_LEN(4)) dut  (.clk(clk), .rst(rst), .s(i4));
  fifo_stream_out #(.WIDTH(W), .BURST_LEN(3)) dut3 (.clk(clk), .rst(rst), .s(i3));

  always #5 clk = ~clk;

  assign i4.fifo_empty = (rd4 >= wr);
  assign i3.fifo_empty = (rd3 >= wr);
  assign i4.m_ready    = rdy;
  assign i3.m_ready    = rdy;

  // fifo_mono model plus reference counts: rdN = words read since reset,
  // arrN = words that have reached the stage (one edge after their read),
  // nN = beats accepted downstream.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd4 <= wr; base4 <= wr; arr4 <= 0; n4 <= 0;
      rd3 <= wr; base3 <= wr; arr3 <= 0; n3 <= 0;
      i4.fifo_dout <= '0;
      i3.fifo_dout <= '0;
    end else begin
      if (i4.fifo_read) begin
        i4.fifo_dout <= mem[rd4];
        rd4 <= rd4 + 1;
      end
      if (i3.fifo_read) begin
        i3.fifo_dout <= mem[rd3];
        rd3 <= rd3 + 1;
      end
      arr4 <= rd4 - base4;
      arr3 <= rd3 - base3;
      if (rdy && arr4 > n4) n4 <= n4 + 1;
      if (rdy && arr3 > n3) n3 <= n3 + 1;
    end
  end

  task automatic push(input logic [W-1:0] v);
    mem[wr] = v;
    wr = wr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 1) push(8'h55);
      #1;
      ntests++;
      if (i4.fifo_read !== 1'b0) begin
        nfail++; $display("FAIL reset_fifo_read c=%0d got=%b exp=0", c, i4.fifo_read);
      end
      ntests++;
      if (i4.m_valid !== 1'b0 || i3.m_valid !== 1'b0) begin
        nfail++; $display("FAIL reset_m_valid c=%0d got=%b/%b exp=0", c, i4.m_valid, i3.m_valid);
      end
      ntests++;
      if (i4.m_last !== 1'b0) begin
        nfail++; $display("FAIL reset_m_last c=%0d got=%b exp=0", c, i4.m_last);
      end
      ntests++;
      if (i4.m_data !== 8'h00) begin
        nfail++; $display("FAIL reset_m_data c=%0d got=%h exp=00", c, i4.m_data);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_latency();
    int cyc_rd, cyc_v, got;
    logic [W-1:0] d [4];
    int cy [4];
    logic [3:0] lm;
    cyc_rd = -1; cyc_v = -1; got = 0; lm = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rdy = 1'b1;
        for (int v = 1; v <= 4; v++) push(W'(v));
      end
      #1;
      if (i4.fifo_read === 1'b1 && cyc_rd < 0) cyc_rd = c;
      if (i4.m_valid === 1'b1 && got < 4) begin
        if (cyc_v < 0) cyc_v = c;
        d[got] = i4.m_data; cy[got] = c; lm[got] = i4.m_last; got++;
      end
    end
    ntests++;
    if (cyc_rd != 0) begin
      nfail++; $display("FAIL lat_first_read got=%0d exp=0", cyc_rd);
    end
    ntests++;
    if (cyc_v != cyc_rd + 2) begin
      nfail++; $display("FAIL lat_first_valid got=%0d exp=%0d", cyc_v, cyc_rd + 2);
    end
    ntests++;
    if (got != 4) begin
      nfail++; $display("FAIL lat_count got=%0d exp=4", got);
    end else begin
      for (int k = 0; k < 4; k++) begin
        ntests++;
        if (d[k] !== W'(k + 1) || cy[k] != cy[0] + k) begin
          nfail++; $display("FAIL lat_beat%0d got=%h@%0d exp=%h@%0d", k, d[k], cy[k], k + 1, cy[0] + k);
        end
      end
      ntests++;
      if (lm !== 4'b1000) begin
        nfail++; $display("FAIL lat_last got=%b exp=1000", lm);
      end
    end
  endtask

  task automatic test_backpressure();
    int nrd, got;
    logic [W-1:0] d [6];
    int cy [6];
    logic [5:0] lm;
    nrd = 0; got = 0; lm = '0;
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) for (int v = 5; v <= 10; v++) push(W'(v));
      #1;
      if (i4.fifo_read === 1'b1) nrd++;
      if (c >= 2) begin
        ntests++;
        if (i4.m_valid !== 1'b1 || i4.m_data !== 8'd5) begin
          nfail++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/05", c, i4.m_valid, i4.m_data);
        end
      end
    end
    ntests++;
    if (nrd != 2) begin
      nfail++; $display("FAIL bp_reads got=%0d exp=2", nrd);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = 1'b1;
      #1;
      if (i4.m_valid === 1'b1) begin
        if (got < 6) begin d[got] = i4.m_data; cy[got] = c; lm[got] = i4.m_last; end
        got++;
      end
    end
    ntests++;
    if (got != 6) begin
      nfail++; $display("FAIL bp_count got=%0d exp=6", got);
    end else begin
      for (int k = 0; k < 6; k++) begin
        ntests++;
        if (d[k] !== W'(5 + k) || cy[k] != k) begin
          nfail++; $display("FAIL bp_beat%0d got=%h@%0d exp=%h@%0d", k, d[k], cy[k], 5 + k, k);
        end
      end
      // Beats 5..10 since reset: the 8th beat closes the second burst.
      ntests++;
      if (lm !== 6'b001000) begin
        nfail++; $display("FAIL bp_last got=%b exp=001000", lm);
      end
    end
  endtask

  task automatic test_toggle();
    int got, vr, vo;
    logic [W-1:0] seq [16];
    got = 0; vr = 0; vo = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) for (int v = 20; v <= 27; v++) push(W'(v));
      rdy = (c % 2 == 0);
      #1;
      if (i4.fifo_read === 1'b1 && i4.fifo_empty === 1'b1) vr++;
      if (rd4 - base4 - n4 > 2) vo++;
      if (i4.m_valid === 1'b1 && rdy) begin
        if (got < 16) seq[got] = i4.m_data;
        got++;
      end
    end
    ntests++;
    if (got != 8) begin
      nfail++; $display("FAIL tog_count got=%0d exp=8", got);
    end else begin
      for (int k = 0; k < 8; k++) begin
        ntests++;
        if (seq[k] !== W'(20 + k)) begin
          nfail++; $display("FAIL tog_beat%0d got=%h exp=%h", k, seq[k], 20 + k);
        end
      end
    end
    ntests++;
    if (vr != 0) begin
      nfail++; $display("FAIL tog_read_empty got=%0d exp=0", vr);
    end
    ntests++;
    if (vo != 0) begin
      nfail++; $display("FAIL tog_occupancy got=%0d exp=0", vo);
    end
  endtask

  task automatic test_burst_wrap();
    int got;
    logic [W-1:0] d [9];
    logic [8:0] lm;
    got = 0; lm = '0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rdy = 1'b1;
        for (int v = 1; v <= 4; v++) push(W'(v));
      end
      if (c == 12) for (int v = 5; v <= 9; v++) push(W'(v));
      #1;
      if (c == 10) begin
        ntests++;
        if (i3.m_valid !== 1'b0) begin
          nfail++; $display("FAIL wrap_pause_valid got=%b exp=0", i3.m_valid);
        end
      end
      if (i3.m_valid === 1'b1) begin
        if (got < 9) begin d[got] = i3.m_data; lm[got] = i3.m_last; end
        got++;
      end
    end
    ntests++;
    if (got != 9) begin
      nfail++; $display("FAIL wrap_count got=%0d exp=9", got);
    end else begin
      for (int k = 0; k < 9; k++) begin
        ntests++;
        if (d[k] !== W'(k + 1)) begin
          nfail++; $display("FAIL wrap_beat%0d got=%h exp=%h", k, d[k], k + 1);
        end
      end
      ntests++;
      if (lm !== 9'b100100100) begin
        nfail++; $display("FAIL wrap_last got=%b exp=100100100", lm);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int got;
    logic [W-1:0] d [4];
    logic [3:0] lm;
    got = 0; lm = '0;
    rdy = 1'b0;
    @(negedge clk);
    for (int v = 8'h31; v <= 8'h34; v++) push(W'(v));
    @(negedge clk);
    @(negedge clk);
    #1;
    ntests++;
    if (i4.m_valid !== 1'b1 || i4.fifo_read !== 1'b0) begin
      nfail++; $display("FAIL mid_prestate got=%b/%b exp=1/0", i4.m_valid, i4.fifo_read);
    end
    #2 rst = 1'b0;
    #1;
    ntests++;
    if (i4.m_valid !== 1'b0 || i4.m_data !== 8'h00 || i4.m_last !== 1'b0 || i4.fifo_read !== 1'b0) begin
      nfail++;
      $display("FAIL mid_async_clear got=v%b d%h l%b r%b exp=v0 d00 l0 r0",
               i4.m_valid, i4.m_data, i4.m_last, i4.fifo_read);
    end
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    for (int v = 8'hAA; v <= 8'hAD; v++) push(W'(v));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (i4.m_valid === 1'b1) begin
        if (got < 4) begin d[got] = i4.m_data; lm[got] = i4.m_last; end
        got++;
      end
    end
    ntests++;
    if (got != 4) begin
      nfail++; $display("FAIL mid_count got=%0d exp=4", got);
    end else begin
      for (int k = 0; k < 4; k++) begin
        ntests++;
        if (d[k] !== W'(8'hAA + k)) begin
          nfail++; $display("FAIL mid_beat%0d got=%h exp=%h", k, d[k], 8'hAA + k);
        end
      end
      ntests++;
      if (lm !== 4'b1000) begin
        nfail++; $display("FAIL mid_last got=%b exp=1000", lm);
      end
    end
  endtask

  task automatic test_random();
    int rp, pp, outs4, outs3;
    logic pop4, pop3, erd4, erd3, ev4, ev3;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      case ((c / 100) % 5)
        0:       begin rp = 9;  pp = 8;  end
        1:       begin rp = 5;  pp = 3;  end
        2:       begin rp = 2;  pp = 10; end
        3:       begin rp = 10; pp = 5;  end
        default: begin rp = 7;  pp = 6;  end
      endcase
      rdy = ($urandom_range(0, 9) < rp);
      if ($urandom_range(0, 9) < pp) push(W'($urandom_range(0, 255)));
      #1;
      ev4   = (arr4 > n4);
      ev3   = (arr3 > n3);
      pop4  = rdy && ev4;
      pop3  = rdy && ev3;
      outs4 = rd4 - base4 - n4 - (pop4 ? 1 : 0);
      outs3 = rd3 - base3 - n3 - (pop3 ? 1 : 0);
      erd4  = (rd4 < wr) && (outs4 < 2);
      erd3  = (rd3 < wr) && (outs3 < 2);
      ntests++;
      if (i4.fifo_read !== erd4 || i3.fifo_read !== erd3) begin
        nfail++; $display("FAIL rand_read c=%0d got=%b/%b exp=%b/%b", c, i4.fifo_read, i3.fifo_read, erd4, erd3);
      end
      ntests++;
      if (i4.m_valid !== ev4 || i3.m_valid !== ev3) begin
        nfail++; $display("FAIL rand_valid c=%0d got=%b/%b exp=%b/%b", c, i4.m_valid, i3.m_valid, ev4, ev3);
      end
      ntests++;
      if (ev4) begin
        if (i4.m_data !== mem[base4 + n4] || i4.m_last !== (n4 % 4 == 3)) begin
          nfail++;
          $display("FAIL rand_beat4 c=%0d got=%h/%b exp=%h/%b", c, i4.m_data, i4.m_last,
                   mem[base4 + n4], (n4 % 4 == 3));
        end
      end else if (i4.m_data !== 8'h00 || i4.m_last !== 1'b0) begin
        nfail++; $display("FAIL rand_idle4 c=%0d got=%h/%b exp=00/0", c, i4.m_data, i4.m_last);
      end
      ntests++;
      if (ev3) begin
        if (i3.m_data !== mem[base3 + n3] || i3.m_last !== (n3 % 3 == 2)) begin
          nfail++;
          $display("FAIL rand_beat3 c=%0d got=%h/%b exp=%h/%b", c, i3.m_data, i3.m_last,
                   mem[base3 + n3], (n3 % 3 == 2));
        end
      end else if (i3.m_data !== 8'h00 || i3.m_last !== 1'b0) begin
        nfail++; $display("FAIL rand_idle3 c=%0d got=%h/%b exp=00/0", c, i3.m_data, i3.m_last);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle();
    test_burst_wrap();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
